// File: rtl/path_meter_pkg.sv
// Shared types and defaults for the path delay meter.
// Holds the measurement FSM state encoding and default widths/limits.
package path_meter_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        WAIT,
        NEXT,
        DONE
    } state_e;

endpackage

// File: rtl/path_sync.sv
// Multi-stage synchronizer for the asynchronous chain result.
// Ports: clk, rst_n (sync, active-low), i_d (async in), o_q (synced out).
module path_sync #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE", keep = "true" *)
    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff <= {STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches transitions into a delay chain and times the synchronized return.
// Ports: clk, rst_n, start -> pathInput; pathResult -> busy, done,
// timeout_err, delay_last/min/max, delay_sum (results over 2^TRIALS_LOG2 trials).
module path_delay_meter
    import path_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TRIALS_LOG2 = 3,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int INVERTING   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         pathInput,
    input  logic                         pathResult,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err,
    output logic [CNT_W-1:0]             delay_last,
    output logic [CNT_W-1:0]             delay_min,
    output logic [CNT_W-1:0]             delay_max,
    output logic [CNT_W+TRIALS_LOG2-1:0] delay_sum
);

    localparam int SUM_W = CNT_W + TRIALS_LOG2;
    localparam logic INV = (INVERTING != 0);
    // Limit is hit on the edge where the counter would become TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_path_in;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [TRIALS_LOG2-1:0] r_idx;
    logic [CNT_W-1:0]       r_last;
    logic [CNT_W-1:0]       r_min;
    logic [CNT_W-1:0]       r_max;
    logic [SUM_W-1:0]       r_sum;
    logic                   w_sync;
    logic                   w_match;
    logic                   w_tmo;
    logic                   w_last_trial;

    path_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (INV)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pathResult),
        .o_q   (w_sync)
    );

    assign w_match      = (w_sync == (r_path_in ^ INV));
    assign w_tmo        = (r_cnt == TMO_M1);
    assign w_last_trial = &r_idx;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE: begin
                if (w_match)    w_next = LAUNCH;
                else if (w_tmo) w_next = DONE;
            end
            LAUNCH:  w_next = WAIT;
            WAIT: begin
                if (w_match)    w_next = NEXT;
                else if (w_tmo) w_next = DONE;
            end
            NEXT:    w_next = w_last_trial ? DONE : LAUNCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_path_in <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_last    <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_sum     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE) && (w_next != DONE);
            r_done  <= (w_next == DONE);
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sum <= '0;
                        r_min <= '1;
                        r_max <= '0;
                        r_err <= 1'b0;
                        r_idx <= '0;
                        r_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!w_match) begin
                        if (w_tmo) r_err <= 1'b1;
                        else       r_cnt <= r_cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    r_path_in <= ~r_path_in;
                    r_cnt     <= '0;
                end
                WAIT: begin
                    if (w_match) begin
                        r_last <= r_cnt;
                        r_sum  <= r_sum + {{TRIALS_LOG2{1'b0}}, r_cnt};
                        if (r_cnt < r_min) r_min <= r_cnt;
                        if (r_cnt > r_max) r_max <= r_cnt;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (!w_last_trial) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pathInput   = r_path_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_err;
    assign delay_last  = r_last;
    assign delay_min   = r_min;
    assign delay_max   = r_max;
    assign delay_sum   = r_sum;

endmodule

// File: tb/tb_path_delay_meter.sv
// Scoreboard bench for path_delay_meter with behavioural delay chains.
// Expected run results are queued at start and compared on each done pulse.
module tb_path_delay_meter;

    typedef struct {
        logic [15:0] last;
        logic [18:0] sum;
        logic [15:0] mn;
        logic [15:0] mx;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pin;
    logic        pres;
    logic        busy, done, err;
    logic [15:0] d_last, d_min, d_max;
    logic [18:0] d_sum;

    logic        start_i = 1'b0;
    logic        pin_i;
    logic        pres_i;
    logic        busy_i, done_i, err_i;
    logic [15:0] l_i, mn_i, mx_i;
    logic [18:0] s_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          d_rise = 5;
    int          d_fall = 5;
    logic        stuck = 1'b0;
    logic [31:0] hist = '0;
    exp_t        q[$];
    exp_t        qi[$];

    always #5 clk = ~clk;

    path_delay_meter #(.TIMEOUT(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pathInput(pin), .pathResult(pres),
        .busy(busy), .done(done), .timeout_err(err),
        .delay_last(d_last), .delay_min(d_min),
        .delay_max(d_max), .delay_sum(d_sum)
    );

    path_delay_meter #(.INVERTING(1)) u_inv (
        .clk(clk), .rst_n(rst_n), .start(start_i),
        .pathInput(pin_i), .pathResult(pres_i),
        .busy(busy_i), .done(done_i), .timeout_err(err_i),
        .delay_last(l_i), .delay_min(mn_i),
        .delay_max(mx_i), .delay_sum(s_i)
    );

    // Chain model: output follows the input delayed by the delay of
    // the edge direction that produced the current input level.
    always @(posedge clk) begin
        hist <= {hist[30:0], pin};
        cyc  <= cyc + 1;
    end

    always_comb begin
        pres = 1'b0;
        if (stuck)       pres = 1'b0;
        else if (pin)    pres = (d_rise == 0) ? pin : hist[5'(d_rise - 1)];
        else             pres = (d_fall == 0) ? pin : hist[5'(d_fall - 1)];
    end

    assign pres_i = ~pin_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("last", 32'(d_last), 32'(e.last));
                chk("sum",  32'(d_sum),  32'(e.sum));
                chk("min",  32'(d_min),  32'(e.mn));
                chk("max",  32'(d_max),  32'(e.mx));
                chk("err",  32'(err),    32'(e.err));
            end else begin
                chk("spurious_done", 32'd1, 32'd0);
            end
        end
        if (rst_n && done_i) begin
            if (qi.size() > 0) begin
                e = qi.pop_front();
                chk("inv_last", 32'(l_i),  32'(e.last));
                chk("inv_sum",  32'(s_i),  32'(e.sum));
                chk("inv_min",  32'(mn_i), 32'(e.mn));
                chk("inv_max",  32'(mx_i), 32'(e.mx));
                chk("inv_err",  32'(err_i), 32'(e.err));
            end else begin
                chk("inv_spurious_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_toggle(output int tc);
        logic old;
        bit   hit;
        old = pin;
        hit = 1'b0;
        tc  = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            if (pin != old) begin
                hit = 1'b1;
                tc  = cyc;
            end
        end
        chk("toggle_seen", 32'(hit), 32'd1);
    endtask

    task automatic wait_done(output int tc);
        bit seen;
        seen = 1'b0;
        tc   = 0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                tc   = cyc;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run(input exp_t e, input bit mid_start);
        int base, t;
        base = done_cnt;
        q.push_back(e);
        pulse_start();
        chk("busy_run", 32'(busy), 32'd1);
        if (mid_start) begin
            wait_toggle(t);
            @(negedge clk);
            @(negedge clk);
            pulse_start();
        end
        wait_done(t);
        repeat (4) @(negedge clk);
        chk("done_once", 32'(done_cnt - base), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int t0, t1, base;
        bit seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pin",  32'(pin),    32'd0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_done", 32'(done),   32'd0);
        chk("rst_err",  32'(err),    32'd0);
        chk("rst_last", 32'(d_last), 32'd0);
        chk("rst_sum",  32'(d_sum),  32'd0);
        chk("rst_min",  32'(d_min),  32'd0);
        chk("rst_max",  32'(d_max),  32'd0);

        d_rise = 5; d_fall = 5;
        run('{16'd7, 19'd56, 16'd7, 16'd7, 1'b0}, 1'b0);

        d_rise = 3; d_fall = 6;
        run('{16'd8, 19'd52, 16'd5, 16'd8, 1'b0}, 1'b0);
        chk("alt_pin_end", 32'(pin), 32'd0);

        d_rise = 5; d_fall = 5;
        run('{16'd7, 19'd56, 16'd7, 16'd7, 1'b0}, 1'b1);

        stuck = 1'b1;
        base  = done_cnt;
        q.push_back('{16'd7, 19'd0, 16'hFFFF, 16'd0, 1'b1});
        pulse_start();
        wait_toggle(t0);
        wait_done(t1);
        chk("tmo_latency", 32'(t1 - t0), 32'd20);
        repeat (4) @(negedge clk);
        chk("tmo_done_once", 32'(done_cnt - base), 32'd1);
        chk("tmo_err_hold", 32'(err), 32'd1);
        stuck = 1'b0;
        repeat (10) @(negedge clk);

        base = done_cnt;
        pulse_start();
        chk("rst_run_err_clr", 32'(err), 32'd0);
        wait_toggle(t0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_pin",  32'(pin),    32'd0);
        chk("mid_busy", 32'(busy),   32'd0);
        chk("mid_done", 32'(done),   32'd0);
        chk("mid_err",  32'(err),    32'd0);
        chk("mid_last", 32'(d_last), 32'd0);
        chk("mid_sum",  32'(d_sum),  32'd0);
        chk("mid_min",  32'(d_min),  32'd0);
        chk("mid_max",  32'(d_max),  32'd0);
        repeat (30) @(negedge clk);
        chk("mid_no_done", 32'(done_cnt - base), 32'd0);

        run('{16'd7, 19'd56, 16'd7, 16'd7, 1'b0}, 1'b0);

        qi.push_back('{16'd2, 19'd16, 16'd2, 16'd2, 1'b0});
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (done_i) seen = 1'b1;
        end
        chk("inv_done_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);

        chk("q_left",  32'(q.size()),  32'd0);
        chk("qi_left", 32'(qi.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
